host_mem_ctrl: RTL and testbench

Host-side controller that sits directly upstream of the multi-core `top`. It replaces file-driven stimulus with a streaming interface:
- accepts a valid/ready word stream and writes it into shared memory through the `com_*` port (status 00);
- releases the cores to run (status 01) and counts run cycles;
- after `end_process`, reads back a fixed window of memory (status 10) and streams it out with backpressure.

---
 rtl/host_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_host_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_ctrl.sv
// Host-side controller: streams a load image into shared memory, lets the cores run,
// then reads back a fixed window of memory and streams it out under backpressure.
module host_mem_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DUMP_WORDS = 256,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] com_addr,
  output logic [DATA_W-1:0] com_data_in,
  output logic              com_wr_en,
  input  logic              end_process,
  input  logic [DATA_W-1:0] com_data_out,
  output logic [31:0]       run_cycles,
  output logic              done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST_J    = ADDR_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_W-1:0] LP_LAST_K    = {ADDR_W{1'b1}};
  localparam logic [1:0]        LP_WAIT_LAST = 2'(READ_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_k;
  logic [ADDR_W-1:0]   r_j;
  logic [1:0]          r_wait;
  logic [ADDR_W-1:0]   r_com_addr;
  logic [DATA_W-1:0]   r_com_data_in;
  logic                r_com_wr_en;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic [31:0]         r_run_cycles;

  logic                w_load_hs;
  logic                w_load_end;
  logic                w_out_hs;
  logic                w_wait_done;
  logic                w_last_j;

  // in_ready is masked by rst so it reads 0 throughout the reset cycle.
  assign in_ready    = (r_state == S_LOAD) & ~rst;
  assign w_load_hs   = in_valid & in_ready;
  assign w_load_end  = w_load_hs & (in_last | (r_k == LP_LAST_K));
  assign w_out_hs    = r_out_valid & out_ready;
  assign w_wait_done = (r_wait == LP_WAIT_LAST);
  assign w_last_j    = (r_j == LP_LAST_J);

  assign com_addr    = r_com_addr;
  assign com_data_in = r_com_data_in;
  assign com_wr_en   = r_com_wr_en;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign run_cycles  = r_run_cycles;
  assign done        = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    status = 2'b10;
    case (r_state)
      S_LOAD: begin
        status = 2'b00;
        if (w_load_end) w_next = S_RUN;
      end
      S_RUN: begin
        status = 2'b01;
        if (end_process) w_next = S_DUMP_RD;
      end
      S_DUMP_RD:   w_next = S_DUMP_WAIT;
      S_DUMP_WAIT: if (w_wait_done) w_next = S_DUMP_OUT;
      S_DUMP_OUT:  if (w_out_hs) w_next = w_last_j ? S_DONE : S_DUMP_RD;
      S_DONE:      w_next = S_DONE;
      default:     w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k           <= '0;
      r_j           <= '0;
      r_wait        <= '0;
      r_com_addr    <= '0;
      r_com_data_in <= '0;
      r_com_wr_en   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_run_cycles  <= '0;
    end else begin
      // Write strobe is a one-cycle pulse following each accepted load word.
      r_com_wr_en <= 1'b0;
      if (w_load_hs) begin
        r_com_addr    <= r_k;
        r_com_data_in <= in_data;
        r_com_wr_en   <= 1'b1;
        r_k           <= r_k + 1'b1;
      end
      if (r_state == S_RUN) begin
        if (r_run_cycles != 32'hFFFF_FFFF) r_run_cycles <= r_run_cycles + 1'b1;
        if (end_process) r_j <= '0;
      end
      if (r_state == S_DUMP_RD) begin
        r_com_addr <= r_j;
        r_wait     <= '0;
      end
      if (r_state == S_DUMP_WAIT) begin
        if (w_wait_done) begin
          r_out_data  <= com_data_out;
          r_out_valid <= 1'b1;
          r_out_last  <= w_last_j;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_j         <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_host_mem_ctrl.sv
// Directed bench for host_mem_ctrl: small address space (4 bits), 4-word dump window,
// memory model answering addr*3 on the read path.
module tb_host_mem_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    status;
  logic [AW-1:0] com_addr;
  logic [DW-1:0] com_data_in;
  logic          com_wr_en;
  logic          end_process;
  logic [DW-1:0] com_data_out;
  logic [31:0]   run_cycles;
  logic          done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  host_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DUMP_WORDS(NW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .status(status), .com_addr(com_addr), .com_data_in(com_data_in), .com_wr_en(com_wr_en),
    .end_process(end_process), .com_data_out(com_data_out),
    .run_cycles(run_cycles), .done(done)
  );

  always #5 clk = ~clk;

  assign com_data_out = 16'(com_addr) * 16'd3;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    end_process = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Loads n words (in_last on the final one) then pulses end_process; returns in DUMP_RD.
  task automatic quick_load_run(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = 16'(100 + i); in_last = (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    end_process = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (status !== 2'b00) $display("FAIL rst_status got %b want 00", status); else pass_cnt++;
    chk_cnt++; if (com_wr_en !== 1'b0 || com_addr !== 4'd0 || com_data_in !== 16'd0)
      $display("FAIL rst_com got wr=%b addr=%0d din=%0d want 0/0/0", com_wr_en, com_addr, com_data_in); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_out got v=%b d=%0d l=%b done=%b want all 0", out_valid, out_data, out_last, done); else pass_cnt++;
    chk_cnt++; if (run_cycles !== 32'd0) $display("FAIL rst_run_cycles got %0d want 0", run_cycles); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_load_gapped;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(5 + i); in_last = (i == 2); end_process = (i == 2);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; end_process = 1'b0;
      chk_cnt++; if (com_wr_en !== 1'b1 || com_addr !== 4'(i) || com_data_in !== 16'(5 + i))
        $display("FAIL gap_wr%0d got wr=%b addr=%0d din=%0d want 1/%0d/%0d", i, com_wr_en, com_addr, com_data_in, i, 5 + i);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (com_wr_en !== 1'b0) $display("FAIL gap_idle%0d got wr=%b want 0", i, com_wr_en); else pass_cnt++;
      chk_cnt++; if (status !== ((i == 2) ? 2'b01 : 2'b00))
        $display("FAIL gap_status%0d got %b want %b", i, status, (i == 2) ? 2'b01 : 2'b00); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (status !== 2'b01) $display("FAIL gap_ep_ignored got status %b want 01", status); else pass_cnt++;
  endtask

  task automatic test_load_cont;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(10 * (i + 1)); in_last = (i == 3); end_process = (i == 1);
      @(negedge clk);
      end_process = 1'b0;
      chk_cnt++; if (com_wr_en !== 1'b1 || com_addr !== 4'(i) || com_data_in !== 16'(10 * (i + 1)))
        $display("FAIL cont_wr%0d got wr=%b addr=%0d din=%0d want 1/%0d/%0d", i, com_wr_en, com_addr, com_data_in, i, 10 * (i + 1));
      else pass_cnt++;
      chk_cnt++; if (status !== ((i == 3) ? 2'b01 : 2'b00) || in_ready !== (i != 3))
        $display("FAIL cont_state%0d got status=%b rdy=%b", i, status, in_ready); else pass_cnt++;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_run;
    @(negedge clk);
    chk_cnt++; if (com_wr_en !== 1'b0) $display("FAIL run_wr got %b want 0", com_wr_en); else pass_cnt++;
    repeat (98) @(negedge clk);
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    chk_cnt++; if (status !== 2'b10) $display("FAIL run_status got %b want 10", status); else pass_cnt++;
    chk_cnt++; if (run_cycles !== 32'd100) $display("FAIL run_cycles got %0d want 100", run_cycles); else pass_cnt++;
  endtask

  task automatic test_dump;
    int cnt;
    out_ready = 1'b1;
    for (int j = 0; j < NW; j++) begin
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
      chk_cnt++; if (cnt !== RL + 1) $display("FAIL dump_lat%0d got %0d want %0d", j, cnt, RL + 1); else pass_cnt++;
      chk_cnt++; if (out_data !== 16'(3 * j) || out_last !== (j == NW - 1) || com_addr !== 4'(j))
        $display("FAIL dump_word%0d got d=%0d l=%b addr=%0d want %0d/%b/%0d", j, out_data, out_last, com_addr, 3 * j, j == NW - 1, j);
      else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL dump_early_done%0d got %b want 0", j, done); else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++; if (done !== 1'b1 || out_valid !== 1'b0 || status !== 2'b10)
      $display("FAIL dump_done got done=%b v=%b status=%b want 1/0/10", done, out_valid, status); else pass_cnt++;
    end_process = 1'b1;
    repeat (3) @(negedge clk);
    end_process = 1'b0;
    chk_cnt++; if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || run_cycles !== 32'd100)
      $display("FAIL done_hold got done=%b v=%b rdy=%b rc=%0d", done, out_valid, in_ready, run_cycles); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int cnt;
    do_reset();
    quick_load_run(1);
    out_ready = 1'b1;
    for (int j = 0; j < NW; j++) begin
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
      chk_cnt++; if (cnt !== RL + 1 || out_data !== 16'(3 * j) || out_last !== (j == NW - 1))
        $display("FAIL bp_word%0d got lat=%0d d=%0d l=%b want %0d/%0d/%b", j, cnt, out_data, out_last, RL + 1, 3 * j, j == NW - 1);
      else pass_cnt++;
      if (j == 2) begin
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          chk_cnt++; if (out_valid !== 1'b1 || out_data !== 16'd6 || com_addr !== 4'd2)
            $display("FAIL bp_hold%0d got v=%b d=%0d addr=%0d want 1/6/2", k, out_valid, out_data, com_addr);
          else pass_cnt++;
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk_cnt++; if (done !== 1'b1) $display("FAIL bp_done got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int cnt;
    do_reset();
    quick_load_run(2);
    out_ready = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mrst_reach_out got v=%b want 1", out_valid); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (status !== 2'b00 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mrst_state got status=%b v=%b done=%b rdy=%b want 00/0/0/1", status, out_valid, done, in_ready);
    else pass_cnt++;
    chk_cnt++; if (out_data !== 16'd0 || run_cycles !== 32'd0 || com_addr !== 4'd0)
      $display("FAIL mrst_regs got d=%0d rc=%0d addr=%0d want 0/0/0", out_data, run_cycles, com_addr); else pass_cnt++;
    in_valid = 1'b1; in_data = 16'd77;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++; if (com_wr_en !== 1'b1 || com_addr !== 4'd0 || com_data_in !== 16'd77)
      $display("FAIL mrst_reload got wr=%b addr=%0d din=%0d want 1/0/77", com_wr_en, com_addr, com_data_in); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (com_wr_en !== 1'b0 || com_data_in !== 16'd0)
      $display("FAIL mrst_cancel_wr got wr=%b din=%0d want 0/0", com_wr_en, com_data_in); else pass_cnt++;
  endtask

  task automatic test_load_limit;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 16'(200 + i); in_last = 1'b0;
      @(negedge clk);
      chk_cnt++; if (com_wr_en !== 1'b1 || com_addr !== 4'(i) || com_data_in !== 16'(200 + i))
        $display("FAIL lim_wr%0d got wr=%b addr=%0d din=%0d", i, com_wr_en, com_addr, com_data_in); else pass_cnt++;
      chk_cnt++; if (status !== ((i == 15) ? 2'b01 : 2'b00))
        $display("FAIL lim_status%0d got %b", i, status); else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++; if (com_wr_en !== 1'b0 || com_addr !== 4'd15 || in_ready !== 1'b0)
      $display("FAIL lim_stop got wr=%b addr=%0d rdy=%b want 0/15/0", com_wr_en, com_addr, in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_gapped();
    do_reset();
    test_load_cont();
    test_run();
    test_dump();
    test_backpressure();
    test_mid_reset();
    test_load_limit();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
